dmem_port_arbiter: RTL and testbench

- Shares port B of the unified dual-port instruction/data BRAM between two requesters: the CPU FSM data path (read/write) and a debug memory viewer (read-only), which feeds the HEX display in show-memory mode.
- The CPU has fixed priority. A starvation counter guarantees the viewer a slot.
- The block sits between the FSM/viewer and bram16 port B, and tracks the BRAM's 1-cycle synchronous read latency so each read result returns to its originator.

---
 rtl/dmem_port_arbiter.sv | 113 +++++++++++
 tb/tb_dmem_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares BRAM port B between the CPU FSM data path (read/write, fixed
//   priority) and the debug memory viewer (read-only). A starvation counter
//   forces one viewer slot after STARVE_LIMIT consecutive denied cycles.
//   Read results are tagged for the BRAM's 1-cycle read latency, so each one
//   returns to the requester that issued it.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   cpu_req/we/addr/din       CPU access request (one cycle per access)
//   cpu_gnt                   CPU access issued this cycle (combinational)
//   cpu_rvalid/cpu_rdata      CPU read return; rdata holds the last read
//   dbg_req/dbg_addr          viewer read request, held until granted
//   dbg_gnt                   viewer access issued this cycle (combinational)
//   dbg_rvalid/dbg_rdata      viewer read return; rdata holds the last read
//   mem_en/we/addr/din        BRAM port B drive
//   mem_dout                  BRAM port B read data (cycle after the read)
//   conflict_cnt              saturating count of cycles with both requesting
module dmem_port_arbiter #(
  parameter int ADDR_WIDTH   = 9,
  parameter int DATA_WIDTH   = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_din,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dbg_req,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [15:0]           conflict_cnt
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic                  rd_cpu_q, rd_cpu_d;
  logic                  rd_dbg_q, rd_dbg_d;
  logic [DATA_WIDTH-1:0] cpu_hold_q, cpu_hold_d;
  logic [DATA_WIDTH-1:0] dbg_hold_q, dbg_hold_d;
  logic [3:0]            starve_q, starve_d;
  logic [15:0]           conflict_q, conflict_d;
  logic                  dbg_force;

  // Arbitration and port drive. Grants and read-valids are masked by rst so
  // nothing reaches the BRAM or the requesters while reset is held.
  always_comb begin
    dbg_force  = dbg_req & (starve_q == STARVE_MAX);
    cpu_gnt    = ~rst & cpu_req & ~dbg_force;
    dbg_gnt    = ~rst & dbg_req & ~cpu_gnt;

    mem_en     = cpu_gnt | dbg_gnt;
    mem_we     = cpu_gnt & cpu_we;
    mem_addr   = cpu_gnt ? cpu_addr : dbg_addr;
    mem_din    = cpu_din;

    cpu_rvalid = rd_cpu_q & ~rst;
    dbg_rvalid = rd_dbg_q & ~rst;
    // Pass-through in the return cycle, otherwise keep showing the last read.
    cpu_rdata  = cpu_rvalid ? mem_dout : cpu_hold_q;
    dbg_rdata  = dbg_rvalid ? mem_dout : dbg_hold_q;

    conflict_cnt = conflict_q;
  end

  // Next-state logic.
  always_comb begin
    rd_cpu_d   = cpu_gnt & ~cpu_we;
    rd_dbg_d   = dbg_gnt;
    cpu_hold_d = cpu_rvalid ? mem_dout : cpu_hold_q;
    dbg_hold_d = dbg_rvalid ? mem_dout : dbg_hold_q;

    starve_d = 4'd0;
    if (dbg_req && !dbg_gnt) begin
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 4'd1;
    end

    conflict_d = conflict_q;
    if (cpu_req && dbg_req && (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cpu_q   <= 1'b0;
      rd_dbg_q   <= 1'b0;
      cpu_hold_q <= '0;
      dbg_hold_q <= '0;
      starve_q   <= 4'd0;
      conflict_q <= 16'd0;
    end else begin
      rd_cpu_q   <= rd_cpu_d;
      rd_dbg_q   <= rd_dbg_d;
      cpu_hold_q <= cpu_hold_d;
      dbg_hold_q <= dbg_hold_d;
      starve_q   <= starve_d;
      conflict_q <= conflict_d;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Testbench for dmem_port_arbiter: directed vectors with a scoreboard.
// Stimulus pushes expected read returns (cycle + data) per requester; a
// negedge monitor pops and compares whenever an rvalid appears.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [8:0]  cpu_addr;
  logic [15:0] cpu_din;
  logic        cpu_gnt, cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic        dbg_req;
  logic [8:0]  dbg_addr;
  logic        dbg_gnt, dbg_rvalid;
  logic [15:0] dbg_rdata;
  logic        mem_en, mem_we;
  logic [8:0]  mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic [15:0] conflict_cnt;

  dmem_port_arbiter #(.ADDR_WIDTH(9), .DATA_WIDTH(16), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous-read BRAM model for port B.
  logic [15:0] mem [0:511];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_din;
      else        mem_dout <= mem[mem_addr];
    end
  end

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } exp_t;

  exp_t cpu_q[$];
  exp_t dbg_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  task automatic push_cpu(input logic [15:0] d);
    exp_t e;
    e.cyc = cyc_n + 1;
    e.data = d;
    cpu_q.push_back(e);
  endtask

  task automatic push_dbg(input logic [15:0] d);
    exp_t e;
    e.cyc = cyc_n + 1;
    e.data = d;
    dbg_q.push_back(e);
  endtask

  // Monitor: compare every read return against the scoreboard.
  exp_t me;
  always @(negedge clk) begin
    while (cpu_q.size() > 0 && cpu_q[0].cyc < cyc_n) begin
      me = cpu_q.pop_front();
      n_cmp++; n_fail++;
      $display("FAIL cpu_rvalid_missing: got 0, expected 1 in cycle %0d", me.cyc);
    end
    while (dbg_q.size() > 0 && dbg_q[0].cyc < cyc_n) begin
      me = dbg_q.pop_front();
      n_cmp++; n_fail++;
      $display("FAIL dbg_rvalid_missing: got 0, expected 1 in cycle %0d", me.cyc);
    end
    if (cpu_rvalid === 1'b1) begin
      if (cpu_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL cpu_rvalid_unexpected: got 1, expected 0 (cycle %0d)", cyc_n);
      end else begin
        me = cpu_q.pop_front();
        chk("cpu_rvalid_cycle", cyc_n, me.cyc);
        chk("cpu_rdata", {16'd0, cpu_rdata}, {16'd0, me.data});
      end
    end
    if (dbg_rvalid === 1'b1) begin
      if (dbg_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL dbg_rvalid_unexpected: got 1, expected 0 (cycle %0d)", cyc_n);
      end else begin
        me = dbg_q.pop_front();
        chk("dbg_rvalid_cycle", cyc_n, me.cyc);
        chk("dbg_rdata", {16'd0, dbg_rdata}, {16'd0, me.data});
      end
    end
  end

  // Advance to the next cycle: inputs change 1 after the edge, checks at +2.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic cr, input logic cw, input logic [8:0] ca,
                     input logic [15:0] cd, input logic dr, input logic [8:0] da);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_din = cd;
    dbg_req = dr; dbg_addr = da;
    #1;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 9'h000, 16'h0000, 1'b0, 9'h000);
  endtask

  task automatic do_reset();
    nxt();
    rst = 1'b1;
    idle();
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    dbg_req = 1'b0; dbg_addr = '0;
    do_reset();

    // Reset state
    idle();
    chk("rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    chk("rst_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    chk("rst_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
    chk("rst_dbg_rdata", {16'd0, dbg_rdata}, 32'd0);
    chk("rst_conflict", {16'd0, conflict_cnt}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);

    // Seed memory through the CPU write path
    nxt(); drv(1'b1, 1'b1, 9'h001, 16'hA001, 1'b0, 9'h000);
    nxt(); drv(1'b1, 1'b1, 9'h002, 16'hA002, 1'b0, 9'h000);
    nxt(); drv(1'b1, 1'b1, 9'h003, 16'hD003, 1'b0, 9'h000);
    nxt(); drv(1'b1, 1'b1, 9'h1FF, 16'hBEEF, 1'b0, 9'h000);

    // Basic write then read, viewer idle
    nxt(); drv(1'b1, 1'b1, 9'h010, 16'h1234, 1'b0, 9'h000);
    chk("wr_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    chk("wr_mem_we", {31'd0, mem_we}, 32'd1);
    chk("wr_mem_en", {31'd0, mem_en}, 32'd1);
    chk("wr_mem_addr", {23'd0, mem_addr}, 32'h010);
    chk("wr_mem_din", {16'd0, mem_din}, 32'h1234);
    nxt(); drv(1'b1, 1'b0, 9'h010, 16'h0000, 1'b0, 9'h000);
    chk("rd_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    chk("rd_mem_we", {31'd0, mem_we}, 32'd0);
    chk("wr_no_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    push_cpu(16'h1234);
    nxt(); idle();
    nxt(); idle();
    chk("cpu_hold", {16'd0, cpu_rdata}, 32'h1234);

    // Viewer read alone
    nxt(); drv(1'b0, 1'b0, 9'h000, 16'h0000, 1'b1, 9'h1FF);
    chk("dbg_gnt", {31'd0, dbg_gnt}, 32'd1);
    chk("dbg_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
    chk("dbg_mem_addr", {23'd0, mem_addr}, 32'h1FF);
    chk("dbg_mem_we", {31'd0, mem_we}, 32'd0);
    push_dbg(16'hBEEF);
    nxt(); idle();
    chk("dbg_no_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    nxt(); idle();
    chk("dbg_hold", {16'd0, dbg_rdata}, 32'hBEEF);
    chk("cpu_hold_kept", {16'd0, cpu_rdata}, 32'h1234);

    // Starvation: CPU reads 0x002 continuously, viewer waits on 0x1FF
    do_reset();
    for (int i = 0; i < 6; i++) begin
      nxt(); drv(1'b1, 1'b0, 9'h002, 16'h0000, 1'b1, 9'h1FF);
      chk($sformatf("starve_cpu_gnt_%0d", i), {31'd0, cpu_gnt}, (i == 4) ? 32'd0 : 32'd1);
      chk($sformatf("starve_dbg_gnt_%0d", i), {31'd0, dbg_gnt}, (i == 4) ? 32'd1 : 32'd0);
      if (i == 4) begin
        chk("starve_mem_addr", {23'd0, mem_addr}, 32'h1FF);
        push_dbg(16'hBEEF);
      end else begin
        push_cpu(16'hA002);
      end
    end
    nxt(); idle();
    chk("starve_conflict", {16'd0, conflict_cnt}, 32'd6);

    // Back-to-back: writes build up starvation, then read 0x001 (N),
    // forced viewer read 0x003 (N+1), CPU read 0x002 (N+2)
    do_reset();
    for (int i = 0; i < 3; i++) begin
      nxt(); drv(1'b1, 1'b1, 9'h020, 16'h5555, 1'b1, 9'h003);
    end
    nxt(); drv(1'b1, 1'b0, 9'h001, 16'h0000, 1'b1, 9'h003);
    chk("b2b_n_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    push_cpu(16'hA001);
    nxt(); drv(1'b1, 1'b0, 9'h004, 16'h0000, 1'b1, 9'h003);
    chk("b2b_n1_dbg_gnt", {31'd0, dbg_gnt}, 32'd1);
    chk("b2b_n1_cpu_lost", {31'd0, cpu_gnt}, 32'd0);
    push_dbg(16'hD003);
    nxt(); drv(1'b1, 1'b0, 9'h002, 16'h0000, 1'b0, 9'h000);
    chk("b2b_n2_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    push_cpu(16'hA002);
    nxt(); idle();
    nxt(); idle();

    // Reset mid-read: build starvation, CPU read, then rst on the next edge
    for (int i = 0; i < 3; i++) begin
      nxt(); drv(1'b1, 1'b1, 9'h030, 16'h7777, 1'b1, 9'h1FF);
    end
    nxt(); drv(1'b1, 1'b0, 9'h001, 16'h0000, 1'b1, 9'h1FF);
    chk("mid_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    nxt(); rst = 1'b1; drv(1'b1, 1'b0, 9'h001, 16'h0000, 1'b1, 9'h1FF);
    chk("mid_rst_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
    chk("mid_rst_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
    chk("mid_rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("mid_rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("mid_rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    nxt(); rst = 1'b0; drv(1'b1, 1'b1, 9'h030, 16'h7777, 1'b1, 9'h1FF);
    chk("post_rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    chk("post_rst_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
    chk("post_rst_dbg_rdata", {16'd0, dbg_rdata}, 32'd0);
    chk("post_rst_conflict", {16'd0, conflict_cnt}, 32'd0);
    chk("post_rst_starve_clr", {31'd0, cpu_gnt}, 32'd1);
    nxt(); idle();

    // Saturation: CPU writes to 0x100 overlap viewer reads of 0x1FF;
    // the viewer wins every fifth cycle
    do_reset();
    for (int i = 0; i < 65537; i++) begin
      nxt(); drv(1'b1, 1'b1, 9'h100, 16'h0F0F, 1'b1, 9'h1FF);
      if ((i % 5) == 4) push_dbg(16'hBEEF);
      if (i < 10 || i >= 65534) begin
        chk($sformatf("sat_dbg_gnt_%0d", i), {31'd0, dbg_gnt}, ((i % 5) == 4) ? 32'd1 : 32'd0);
      end
      if (i == 65534) chk("sat_fffe", {16'd0, conflict_cnt}, 32'hFFFE);
      if (i >= 65535) chk($sformatf("sat_ffff_%0d", i), {16'd0, conflict_cnt}, 32'hFFFF);
    end
    nxt(); idle();
    chk("sat_hold", {16'd0, conflict_cnt}, 32'hFFFF);
    nxt(); idle();
    nxt(); idle();

    chk("cpu_queue_empty", cpu_q.size(), 32'd0);
    chk("dbg_queue_empty", dbg_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
